// File: rtl/seq_det_ctrl.sv
// Run controller around a programmable Mealy serial pattern detector.
// Counts matches on a qualified bit stream and stops on a hit target.
module seq_det_ctrl #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [3:0]       cfg_len,
  input  logic             cfg_overlap,
  input  logic [CNT_W-1:0] cfg_target,
  input  logic             start,
  input  logic             abort,
  input  logic             in_valid,
  input  logic             in,
  output logic             hit,
  output logic [CNT_W-1:0] hit_count,
  output logic             busy,
  output logic             done
);

  localparam int FW = $clog2(PAT_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    DONE
  } state_t;

  state_t state, state_n;

  // Top history bit can never take part in a match, so it is not kept.
  logic [PAT_W-2:0] hist, hist_n;
  logic [FW-1:0]    fill, fill_n, fill_inc;
  logic [PAT_W-1:0] pat, pat_n, mask, cand;
  logic [3:0]       len, len_n, len_c;
  logic             ovl, ovl_n;
  logic [CNT_W-1:0] tgt, tgt_n, cnt, cnt_n, cnt_inc;
  logic             match;

  always_comb begin
    len_c = cfg_len;
    if (cfg_len == 4'd0)
      len_c = 4'd1;
    else if (int'(cfg_len) > PAT_W)
      len_c = 4'(PAT_W);
  end

  always_comb begin
    mask = '0;
    for (int i = 0; i < PAT_W; i++)
      mask[i] = (i < int'(len));
  end

  assign cand = {hist, in};
  assign fill_inc = (int'(fill) >= PAT_W) ? fill : fill + FW'(1);
  assign cnt_inc = (cnt == '1) ? cnt : cnt + CNT_W'(1);

  assign match = !reset && (state == ARMED) && in_valid
              && (int'(fill) + 1 >= int'(len))
              && (((cand ^ pat) & mask) == '0);

  always_comb begin
    state_n = state;
    hist_n  = hist;
    fill_n  = fill;
    cnt_n   = cnt;
    pat_n   = pat;
    len_n   = len;
    ovl_n   = ovl;
    tgt_n   = tgt;
    unique case (state)
      IDLE, DONE: begin
        if (cfg_we) begin
          pat_n = cfg_pattern;
          len_n = len_c;
          ovl_n = cfg_overlap;
          tgt_n = cfg_target;
        end
        if (abort) begin
          state_n = IDLE;
        end else if (start) begin
          hist_n  = '0;
          fill_n  = '0;
          cnt_n   = '0;
          state_n = ARMED;
        end
      end
      ARMED: begin
        if (in_valid) begin
          hist_n = cand[PAT_W-2:0];
          fill_n = fill_inc;
        end
        if (match) begin
          cnt_n = cnt_inc;
          if (!ovl) begin
            hist_n = '0;
            fill_n = '0;
          end
          if (tgt != '0 && cnt_inc == tgt)
            state_n = DONE;
        end
        if (abort)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      hist  <= '0;
      fill  <= '0;
      cnt   <= '0;
      pat   <= PAT_W'(8'h0B);
      len   <= 4'd4;
      ovl   <= 1'b1;
      tgt   <= CNT_W'(1);
    end else begin
      state <= state_n;
      hist  <= hist_n;
      fill  <= fill_n;
      cnt   <= cnt_n;
      pat   <= pat_n;
      len   <= len_n;
      ovl   <= ovl_n;
      tgt   <= tgt_n;
    end
  end

  assign hit       = match;
  assign hit_count = cnt;
  assign busy      = (state == ARMED);
  assign done      = (state == DONE);

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Scoreboard bench for seq_det_ctrl: expected hit per driven cycle
// is queued at drive time and compared on the following falling edge.
module tb_seq_det_ctrl;

  logic       clk;
  logic       reset;
  logic       cfg_we;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_overlap;
  logic [7:0] cfg_target;
  logic       start;
  logic       abort;
  logic       in_valid;
  logic       in;
  logic       hit;
  logic [7:0] hit_count;
  logic       busy;
  logic       done;

  int n_chk;
  int n_fail;
  logic sb[$];

  seq_det_ctrl #(.PAT_W(8), .CNT_W(8)) dut (
    .clk(clk),
    .reset(reset),
    .cfg_we(cfg_we),
    .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap),
    .cfg_target(cfg_target),
    .start(start),
    .abort(abort),
    .in_valid(in_valid),
    .in(in),
    .hit(hit),
    .hit_count(hit_count),
    .busy(busy),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      logic e;
      e = sb.pop_front();
      check("hit", 32'(hit), 32'(e));
    end
  end

  task automatic cyc(input logic v, input logic b,
                     input logic s, input logic a,
                     input logic w, input logic eh);
    @(posedge clk);
    #1;
    in_valid = v;
    in       = b;
    start    = s;
    abort    = a;
    cfg_we   = w;
    sb.push_back(eh);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0);
  endtask

  task automatic bits(input logic [15:0] seq,
                      input logic [15:0] hits,
                      input int n);
    for (int i = 0; i < n; i++)
      cyc(1, seq[n-1-i], 0, 0, 0, hits[n-1-i]);
  endtask

  task automatic setcfg(input logic [7:0] p, input logic [3:0] l,
                        input logic o, input logic [7:0] t);
    cfg_pattern = p;
    cfg_len     = l;
    cfg_overlap = o;
    cfg_target  = t;
    cyc(0, 0, 0, 0, 1, 0);
  endtask

  task automatic status(input string tag, input logic [7:0] c,
                        input logic b, input logic d);
    idle();
    @(negedge clk);
    check({tag, "_cnt"}, 32'(hit_count), 32'(c));
    check({tag, "_busy"}, 32'(busy), 32'(b));
    check({tag, "_done"}, 32'(done), 32'(d));
  endtask

  task automatic arm();
    cyc(0, 0, 1, 0, 0, 0);
  endtask

  task automatic stop();
    cyc(0, 0, 0, 1, 0, 0);
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    reset = 1'b1;
    cfg_we = 0;
    cfg_pattern = '0;
    cfg_len = '0;
    cfg_overlap = 0;
    cfg_target = '0;
    start = 0;
    abort = 0;
    in_valid = 0;
    in = 0;
    repeat (2) @(posedge clk);

    // reset state, hit masked while reset is high
    @(posedge clk);
    #1;
    in_valid = 1;
    in = 1;
    sb.push_back(1'b0);
    @(negedge clk);
    check("rst_cnt", 32'(hit_count), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    @(posedge clk);
    #1;
    reset = 0;
    in_valid = 0;
    in = 0;

    // default 1011, target 1
    arm();
    bits(16'b1011, 16'b0001, 4);
    status("t1", 1, 0, 1);
    cyc(1, 1, 0, 0, 0, 0);
    status("t1_ign", 1, 0, 1);

    // overlap, free running
    setcfg(8'h0B, 4'd4, 1, 8'd0);
    arm();
    bits(16'b1011011, 16'b0001001, 7);
    status("t2", 2, 1, 0);
    stop();
    status("t2_abort", 2, 0, 0);

    // non-overlap
    setcfg(8'h0B, 4'd4, 0, 8'd0);
    arm();
    bits(16'b1011011, 16'b0001000, 7);
    status("t3", 1, 1, 0);
    stop();

    // in_valid gaps with toggling in
    setcfg(8'h0B, 4'd4, 1, 8'd0);
    arm();
    begin
      logic [3:0] s;
      s = 4'b1011;
      for (int i = 0; i < 4; i++) begin
        cyc(1, s[3-i], 0, 0, 0, i == 3);
        for (int k = 0; k < 3; k++)
          cyc(0, k[0] ^ s[3-i], 0, 0, 0, 0);
      end
    end
    status("t4", 1, 1, 0);
    stop();

    // config write ignored while armed
    setcfg(8'h0B, 4'd4, 1, 8'd1);
    arm();
    cfg_pattern = 8'h05;
    cfg_len = 4'd3;
    cyc(1, 1, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 1);
    status("t5", 1, 0, 1);

    // len 0 clamps to 1
    setcfg(8'h0B, 4'd0, 1, 8'd0);
    arm();
    bits(16'b101101, 16'b101101, 6);
    status("t6", 4, 1, 0);
    stop();

    // len 15 clamps to 8
    setcfg(8'hFF, 4'd15, 1, 8'd0);
    arm();
    bits(16'b111111111, 16'b000000011, 9);
    status("t7", 2, 1, 0);
    stop();

    // abort coincident with the second hit
    setcfg(8'h0B, 4'd4, 1, 8'd5);
    arm();
    bits(16'b101101, 16'b000100, 6);
    cyc(1, 1, 0, 1, 0, 1);
    status("t8", 2, 0, 0);
    cyc(0, 0, 1, 1, 0, 0);
    status("t8_sa", 2, 0, 0);
    arm();
    status("t8_rearm", 0, 1, 0);

    // reset mid-run restores default config
    bits(16'b101, 16'b000, 3);
    @(posedge clk);
    #1;
    reset = 1;
    in_valid = 1;
    in = 1;
    sb.push_back(1'b0);
    @(posedge clk);
    #1;
    reset = 0;
    in_valid = 0;
    in = 0;
    status("t9_rst", 0, 0, 0);
    arm();
    bits(16'b1011, 16'b0001, 4);
    status("t9", 1, 0, 1);

    repeat (2) idle();
    @(negedge clk);
    @(negedge clk);
    check("sb_empty", 32'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_det_ctrl.md
Name: seq_det_ctrl

Overview:
- Run controller wrapped around a programmable serial pattern detector (Mealy style, default pattern 1011).
- Holds pattern/length/overlap/target configuration, arms on command and qualifies the serial input stream.
- Counts matches and stops on a programmable hit count.
- Sits between the control/CSR side and a 1-bit serial source; `hit` is combinational on the current input bit, as in the team's existing Mealy detectors.

Parameters:
- PAT_W, 8, maximum pattern length in bits; the history register width.
- CNT_W, 8, width of the hit counter and of the target.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- cfg_we  input  1  config write strobe; honoured only in IDLE or DONE.
- cfg_pattern  input  PAT_W  pattern; bit [len-1] is the first bit received, bit [0] the last.
- cfg_len  input  4  pattern length, valid range 1..PAT_W.
- cfg_overlap  input  1  1 = overlapping matches, 0 = non-overlapping.
- cfg_target  input  CNT_W  number of hits that ends the run; 0 = run until abort.
- start  input  1  arm the run (IDLE/DONE only).
- abort  input  1  stop the run, return to IDLE.
- in_valid  input  1  qualifies `in`.
- in  input  1  serial data bit.
- hit  output  1  combinational Mealy match on the current valid bit.
- hit_count  output  CNT_W  registered number of hits in the current/last run.
- busy  output  1  high in ARMED.
- done  output  1  high in DONE.

Behaviour:
- Reset values:
  - state = IDLE; hist = 0; fill = 0; hit_count = 0; busy = 0; done = 0.
  - Config: pattern = 8'h0B, len = 4, overlap = 1, target = 1.
- Length clamp: cfg_len = 0 is stored as 1; cfg_len > PAT_W is stored as PAT_W.
- States: IDLE, ARMED, DONE.
- IDLE:
  - cfg_we loads the config.
  - start (without abort) clears hist, fill and hit_count; next cycle enters ARMED.
  - start together with abort: abort wins, state stays IDLE.
- ARMED:
  - busy = 1. cfg_we and start are ignored.
  - On each in_valid cycle: hist <= {hist[PAT_W-2:0], in}; fill <= min(fill+1, PAT_W).
  - Cycles without in_valid hold all state; hit = 0.
- Match condition (`hit`):
  - state == ARMED, in_valid = 1, and fill >= len-1.
  - The low `len` bits of {hist, in} equal the low `len` bits of pattern.
  - Zero latency: `hit` is combinational on in/in_valid.
  - hit_count increments on the same clock edge.
- Overlap mode:
  - 1: history continues after a hit, so a suffix can start the next match.
  - 0: on a hit, hist and fill clear to 0 at that edge; the matching bit is not reused.
- Target handling:
  - target != 0 and a hit makes hit_count == target: `hit` is still asserted that cycle, and the state enters DONE at that edge.
  - target = 0: hit_count saturates at 2^CNT_W-1 and the run never self-terminates.
- abort in ARMED: next state IDLE; hit_count is retained; a hit in the same cycle still counts and `hit` still asserts.
- DONE:
  - done = 1 (level); hit_count is held.
  - cfg_we is accepted.
  - start re-arms exactly as from IDLE.
  - abort goes to IDLE.
  - Input bits are ignored.
- reset mid-run: everything returns to its reset values at the next edge, including config; `hit` is 0 while reset is high.

Test Plan:
- Reset, default config, start, then bits 1,0,1,1 -> `hit` = 1 only during the 4th bit; hit_count = 1; done = 1 from the next cycle; busy = 0.
- cfg_target = 0, overlap = 1, stream 1,0,1,1,0,1,1 -> hits on bits 4 and 7; hit_count = 2; done stays 0.
- Same stream with overlap = 0 -> single hit on bit 4; hit_count = 1.
- in_valid gaps: stream 1,0,1,1 with in_valid low for 3 cycles between each bit, and `in` toggling during the gaps -> exactly one hit on the 4th valid bit.
- Config rules:
  - cfg_we in ARMED with pattern 8'h05 -> ignored; the 1011 match still fires.
  - cfg_len = 0 written in IDLE -> read-back behaviour of len 1; pattern bit0 = 1 means every valid 1 is a hit.
- abort after 2 hits (target = 5) -> IDLE, hit_count = 2; start clears it to 0; simultaneous start+abort in IDLE -> remains IDLE.
